// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   alu_op_t    : 4-bit operation code carried on the op port (10..15 reserved).
//   alu_state_t : controller state of alu_seq (IDLE / EXEC / MUL).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ASR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : load operands a/b and begin (ignored while abort is high)
//   abort             : drop any multiplication in progress
//   a, b              : multiplicand / multiplier
//   done              : high during the cycle whose rising edge retires the last step
//   prod_hi, prod_lo  : partial product after the step taken on the coming edge;
//                       equal to the full product {hi,lo} when done is high
// A multiplication started on edge E0 performs its steps on edges E1..E(WIDTH),
// so the full product can be captured by the parent on the WIDTH-th edge.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;   // low product bits shift in from the top as multiplier bits shift out
  logic [WIDTH:0]   sum;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    prod_hi = sum[WIDTH:1];
    prod_lo = {sum[0], lo[WIDTH-1:1]};
  end

  assign done = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      hi    <= '0;
      lo    <= b;
    end else if (run) begin
      hi <= prod_hi;
      lo <= prod_lo;
      if (done) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with accumulator and iterative multiplier.
// Ports:
//   hz100            : clock (rising edge)
//   reset_n          : asynchronous active-low reset
//   en               : enable; low blocks new commands and aborts an in-flight one
//   start            : command request; accepted only in IDLE with en high
//   op, cin, use_acc : operation, carry in, take operand A from the accumulator
//   a, b             : operands
//   result, mul_hi   : registered result (MUL low half) and MUL high half
//   neg, zero, ovf, cout : registered flags
//   busy             : command in flight; done / err : one-cycle completion pulses
// Handshake: start is a request, busy is the inverse of ready. A start seen on a
// rising edge while busy is low and en is high is consumed on that edge; any
// start while busy is high is dropped, never queued. Each accepted command ends
// in exactly one done or err pulse, unless en drops or reset aborts it first.
// Controller state is held in the signal 'state' (alu_state_t).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             hz100,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mul_hi,
  output logic             neg,
  output logic             zero,
  output logic             ovf,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  alu_state_t       state;
  alu_op_t          op_q;
  logic             cin_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] opa;
  logic             accept;
  logic             mul_start;
  logic             mul_abort;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p_hi;
  logic [WIDTH-1:0] mul_p_lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] ex_res;
  logic             ex_cout;
  logic             ex_ovf;
  logic             ex_valid;

  assign opa       = use_acc ? acc : a;
  assign accept    = (state == ST_IDLE) && en && start;
  assign mul_start = accept && (op == OP_MUL);
  assign mul_abort = (state == ST_MUL) && !en;
  assign busy      = (state != ST_IDLE);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (hz100),
    .rst_n   (reset_n),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (opa),
    .b       (b),
    .done    (mul_done),
    .prod_hi (mul_p_hi),
    .prod_lo (mul_p_lo)
  );

  // Single-cycle operations on the latched operands.
  always_comb begin
    sum      = '0;
    ex_res   = '0;
    ex_cout  = 1'b0;
    ex_ovf   = 1'b0;
    ex_valid = 1'b1;
    case (op_q)
      OP_ADD: begin
        sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        ex_res  = sum[MSB:0];
        ex_cout = sum[WIDTH];
        ex_ovf  = (a_q[MSB] == b_q[MSB]) && (ex_res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        // Subtraction as A + ~b + cin; overflow rule applies to the inverted operand.
        sum     = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, cin_q};
        ex_res  = sum[MSB:0];
        ex_cout = sum[WIDTH];
        ex_ovf  = (a_q[MSB] != b_q[MSB]) && (ex_res[MSB] != a_q[MSB]);
      end
      OP_NOT: ex_res = ~a_q;
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_SHL: begin
        ex_res  = {a_q[MSB-1:0], 1'b0};
        ex_cout = a_q[MSB];
      end
      OP_SHR: begin
        ex_res  = {1'b0, a_q[MSB:1]};
        ex_cout = a_q[0];
      end
      OP_ASR: begin
        ex_res  = {a_q[MSB], a_q[MSB:1]};
        ex_cout = a_q[0];
      end
      default: ex_valid = 1'b0;   // reserved codes end in err
    endcase
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      cin_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      result <= '0;
      mul_hi <= '0;
      neg    <= 1'b0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
      cout   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && start) begin
            op_q  <= alu_op_t'(op);
            cin_q <= cin;
            a_q   <= opa;
            b_q   <= b;
            state <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          if (en) begin
            if (ex_valid) begin
              result <= ex_res;
              mul_hi <= '0;
              neg    <= ex_res[MSB];
              zero   <= (ex_res == '0);
              ovf    <= ex_ovf;
              cout   <= ex_cout;
              acc    <= ex_res;
              done   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (mul_done) begin
            result <= mul_p_lo;
            mul_hi <= mul_p_hi;
            neg    <= mul_p_lo[MSB];
            zero   <= (mul_p_lo == '0);
            ovf    <= 1'b0;
            cout   <= (mul_p_hi != '0);
            acc    <= mul_p_lo;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH = 8: directed vector table, hand-written
// multi-cycle sequences (busy window, enable abort, reserved op, reset
// mid-multiply) and random commands against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         hz100 = 1'b0;
  logic         reset_n = 1'b1;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic         cin = 1'b0;
  logic         use_acc = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result, mul_hi;
  logic         neg, zero, ovf, cout, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0] m_acc, m_res, m_hi;
  logic         m_neg, m_zero, m_ovf, m_cout;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         cin, use_acc;
    logic [W-1:0] res, hi;
    logic         neg, zero, ovf, cout;
    int           lat;
  } vec_t;

  vec_t tbl[15];

  alu_seq #(.WIDTH(W)) dut (
    .hz100   (hz100),
    .reset_n (reset_n),
    .en      (en),
    .start   (start),
    .op      (op),
    .cin     (cin),
    .use_acc (use_acc),
    .a       (a),
    .b       (b),
    .result  (result),
    .mul_hi  (mul_hi),
    .neg     (neg),
    .zero    (zero),
    .ovf     (ovf),
    .cout    (cout),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // clock / reset
  always #5 hz100 = ~hz100;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_res = '0; m_hi = '0;
    m_neg = 1'b0; m_zero = 1'b1; m_ovf = 1'b0; m_cout = 1'b0;
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  task automatic model(input logic [3:0] o, input logic [W-1:0] av, bv, input logic c,
                       output logic valid, output logic [W-1:0] r, h,
                       output logic co, ov);
    int ua, ub, sa, sb, s, t;
    ua = int'(av); ub = int'(bv);
    sa = int'($signed(av)); sb = int'($signed(bv));
    valid = 1'b1; r = '0; h = '0; co = 1'b0; ov = 1'b0;
    case (o)
      4'd0: begin
        s = ua + ub + int'(c); r = s[W-1:0]; co = (s > 255);
        t = sa + sb + int'(c); ov = (t > 127) || (t < -128);
      end
      4'd1: begin
        s = ua + (255 - ub) + int'(c); r = s[W-1:0]; co = (s > 255);
        t = sa - sb - 1 + int'(c); ov = (t > 127) || (t < -128);
      end
      4'd2: r = ~av;
      4'd3: r = av & bv;
      4'd4: r = av | bv;
      4'd5: r = av ^ bv;
      4'd6: begin s = (ua * 2) % 256; r = s[W-1:0]; co = av[W-1]; end
      4'd7: begin s = ua / 2; r = s[W-1:0]; co = av[0]; end
      4'd8: begin t = sa >>> 1; r = t[W-1:0]; co = av[0]; end
      4'd9: begin
        s = ua * ub; t = s / 256; r = s[W-1:0]; h = t[W-1:0]; co = (t != 0);
      end
      default: valid = 1'b0;
    endcase
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".result"}, int'(result), int'(m_res));
    chk({tag, ".mul_hi"}, int'(mul_hi), int'(m_hi));
    chk({tag, ".neg"},    int'(neg),    int'(m_neg));
    chk({tag, ".zero"},   int'(zero),   int'(m_zero));
    chk({tag, ".ovf"},    int'(ovf),    int'(m_ovf));
    chk({tag, ".cout"},   int'(cout),   int'(m_cout));
  endtask

  // driver: present a command for one edge, then wait (bounded) for done/err.
  // With spam set, random start pulses are driven while the command is busy.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] av, bv, input logic c, ua,
                       input bit spam, output int lat, output logic gd, output logic ge);
    op = o; a = av; b = bv; cin = c; use_acc = ua; start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
    lat = -1; gd = 1'b0; ge = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge hz100); #1;
      if (done || err) begin
        lat = i; gd = done; ge = err;
        break;
      end
      if (spam) begin
        start = 1'($urandom_range(0, 1));
        op = 4'd0;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [3:0] o, input logic [W-1:0] av, bv,
                        input logic c, ua, input bit spam);
    logic v, co, ov, gd, ge;
    logic [W-1:0] r, h, opnd;
    int lat;
    opnd = ua ? m_acc : av;
    model(o, opnd, bv, c, v, r, h, co, ov);
    issue(o, av, bv, c, ua, spam, lat, gd, ge);
    chk({tag, ".lat"}, lat, (o == 4'd9) ? 8 : 1);
    chk({tag, ".done"}, int'(gd), int'(v));
    chk({tag, ".err"}, int'(ge), int'(!v));
    if (v) begin
      m_res = r; m_hi = h; m_neg = r[W-1]; m_zero = (r == 0);
      m_ovf = ov; m_cout = co; m_acc = r;
    end
    check_outs(tag);
  endtask

  initial begin
    int lat, busy_cnt, late_done;
    logic gd, ge;
    logic [3:0] ro;

    tbl[0]  = '{4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[1]  = '{4'd1, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[2]  = '{4'd0, 8'hEE, 8'h03, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'd6, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{4'd7, 8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[5]  = '{4'd8, 8'h81, 8'h00, 1'b0, 1'b0, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[6]  = '{4'd2, 8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'd4, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'hFC, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'd5, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'hCC, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{4'd9, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    tbl[11] = '{4'd0, 8'h55, 8'h10, 1'b1, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[12] = '{4'd1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[13] = '{4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};

    // reset state
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst");
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err",  int'(err),  0);
    @(posedge hz100); #2;
    reset_n = 1'b1;

    // directed vectors, issued back to back (start right after each done)
    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].use_acc,
            (tbl[i].op == 4'd9), lat, gd, ge);
      chk($sformatf("vec%0d.lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d.done", i), int'(gd), 1);
      m_res = tbl[i].res; m_hi = tbl[i].hi; m_neg = tbl[i].neg;
      m_zero = tbl[i].zero; m_ovf = tbl[i].ovf; m_cout = tbl[i].cout;
      m_acc = tbl[i].res;
      check_outs($sformatf("vec%0d", i));
    end

    // done is a single-cycle pulse
    @(posedge hz100); #1;
    chk("pulse.done", int'(done), 0);
    chk("pulse.busy", int'(busy), 0);

    // MUL busy window with start pulses hammered during it
    op = 4'd9; a = 8'h0D; b = 8'h0B; cin = 1'b0; use_acc = 1'b0; start = 1'b1;
    @(posedge hz100); #1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      if (!busy) break;
      start = 1'b1; op = 4'd0;
      @(posedge hz100); #1;
    end
    start = 1'b0;
    chk("mulbusy.cycles", busy_cnt, 8);
    chk("mulbusy.done", int'(done), 1);
    m_res = 8'h8F; m_hi = 8'h00; m_neg = 1'b1; m_zero = 1'b0; m_ovf = 1'b0; m_cout = 1'b0;
    m_acc = 8'h8F;
    check_outs("mulbusy");
    // the start pulses during busy must not have been queued
    late_done = 0;
    repeat (4) begin
      @(posedge hz100); #1;
      if (done || err || busy) late_done++;
    end
    chk("mulbusy.noqueue", late_done, 0);

    // reserved op: err one edge later, nothing else moves
    do_cmd("rsv12", 4'd12, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    @(posedge hz100); #1;
    chk("rsv12.errpulse", int'(err), 0);

    // enable dropped in the 4th MUL cycle
    op = 4'd9; a = 8'h03; b = 8'h05; cin = 1'b0; use_acc = 1'b0; start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
    repeat (3) begin @(posedge hz100); #1; end
    chk("abort.busy_before", int'(busy), 1);
    en = 1'b0;
    @(posedge hz100); #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    check_outs("abort");
    en = 1'b1;
    late_done = 0;
    repeat (10) begin
      @(posedge hz100); #1;
      if (done || err) late_done++;
    end
    chk("abort.nodone", late_done, 0);
    // accumulator must still hold the pre-abort result
    do_cmd("abort.acc", 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // random commands against the model
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 10));
      if (ro == 4'd10) ro = 4'($urandom_range(10, 15));
      do_cmd($sformatf("rnd%0d", i), ro, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // reset asserted mid-MUL takes effect without a clock edge
    op = 4'd9; a = 8'hFF; b = 8'hFF; cin = 1'b0; use_acc = 1'b0; start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
    repeat (3) begin @(posedge hz100); #1; end
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("rstmul");
    chk("rstmul.busy", int'(busy), 0);
    chk("rstmul.done", int'(done), 0);
    chk("rstmul.err",  int'(err),  0);
    @(posedge hz100); #2;
    reset_n = 1'b1;
    // first edge after release accepts; accumulator was cleared
    do_cmd("postrst", 4'd0, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
